// File: rtl/reg16_write_stage.sv
// reg16_write_stage: small FIFO between the ALU result and Register16b.
// Register16b has no load enable, so this stage holds its input constant between commits.
// Ports:
//   clkpos       - the only clock; all state updates on its rising edge
//   reset        - synchronous, active high
//   vdd, vss     - supply ties, no functional effect
//   wr_valid     - upstream word valid
//   wr_data      - upstream word
//   wr_ready     - stage can accept a word this cycle
//   commit_en    - move the queue head into the register
//   reg_in       - drives in[15:0] of Register16b
//   commit_pulse - reg_in took a new value on the last edge
//   flag_zero    - reg_in is zero
//   flag_neg     - top bit of reg_in
//   commit_cnt   - number of commits, modulo 256
//   occupancy    - number of words currently queued
module reg16_write_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clkpos,
    input  logic                     reset,
    input  logic                     vdd,
    input  logic                     vss,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    input  logic                     commit_en,
    output logic [WIDTH-1:0]         reg_in,
    output logic                     commit_pulse,
    output logic                     flag_zero,
    output logic                     flag_neg,
    output logic [7:0]               commit_cnt,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push;
    logic             pop;
    logic             unused_supply;

    assign unused_supply = ^{vdd, vss};

    // ready looks only at registered occupancy, never at commit_en
    assign wr_ready  = occupancy < OW'(DEPTH);
    assign push      = wr_valid & wr_ready;
    assign pop       = commit_en & (occupancy != '0);
    assign flag_zero = reg_in == '0;
    assign flag_neg  = reg_in[WIDTH-1];

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clkpos) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occupancy    <= '0;
            reg_in       <= '0;
            commit_pulse <= 1'b0;
            commit_cnt   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                commit_cnt <= commit_cnt + 8'd1;
            end
            reg_in       <= pop ? mem[rd_ptr] : reg_in;
            commit_pulse <= pop;
            occupancy    <= occupancy + OW'(push) - OW'(pop);
        end
    end
endmodule
